// File: rtl/wf_iq_capture.sv
// IQ capture buffer: stores {I,Q} pairs from the waterfall CIC in one-shot or ring mode
// and replays them as an interleaved I, Q stream. Optional overrun counter: WF_CAPTURE_OVERRUN_EN.
`timescale 1ns/1ps

module wf_iq_capture #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 13
) (
   input  logic                 adc_clk,
   input  logic                 reset_n,
   input  logic                 wr_rst,
   input  logic                 wr_continuous,
   input  logic                 wr,
   input  logic [WIDTH-1:0]     wr_i,
   input  logic [WIDTH-1:0]     wr_q,
   output logic                 full,
   output logic [ADDR_BITS:0]   wr_count,
   input  logic                 rd_rst,
   input  logic                 rd_sync,
   input  logic                 rd_i,
   input  logic                 rd_q,
   output logic [WIDTH-1:0]     rd_iq
`ifdef WF_CAPTURE_OVERRUN_EN
  ,output logic [15:0]          ovr_count
`endif
);

   localparam int                   DEPTH    = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
   localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS + 1)'(1);
   localparam logic [ADDR_BITS:0]   CNT_LAST = (ADDR_BITS + 1)'(DEPTH - 1);

   logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_BITS:0]   wr_count_q, wr_count_d;
   logic                 full_q, full_d;
   logic [WIDTH-1:0]     rd_iq_q, rd_iq_d;
   logic                 wr_accept;
   logic [2*WIDTH-1:0]   rd_word;
   logic [2*WIDTH-1:0]   mem [DEPTH];

   // One-shot mode refuses writes once full; wr_rst always wins over a coincident wr.
   assign wr_accept = wr && !wr_rst && (wr_continuous || !full_q);

   // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_addr_d  = wr_addr_q;
      wr_count_d = wr_count_q;
      full_d     = full_q;
      if (wr_rst) begin
         wr_addr_d  = '0;
         wr_count_d = '0;
         full_d     = 1'b0;
      end else if (wr_accept) begin
         wr_addr_d = wr_addr_q + ADDR_ONE;
         if (!wr_count_q[ADDR_BITS]) wr_count_d = wr_count_q + CNT_ONE;
         if (wr_count_q == CNT_LAST) full_d = 1'b1;
      end
   end

   always_comb begin
      rd_addr_d = rd_addr_q;
      if (wr_rst || rd_rst) begin
         rd_addr_d = '0;
      end else if (rd_sync) begin
         // Oldest sample in a full ring is the slot the next write would overwrite.
         rd_addr_d = (wr_continuous && full_q) ? wr_addr_d : '0;
      end else if (rd_q) begin
         rd_addr_d = rd_addr_q + ADDR_ONE;
      end
   end

   // Reading the array before the write edge commits gives read-first on collision.
   assign rd_word = mem[rd_addr_q];

   always_comb begin
      rd_iq_d = rd_iq_q;
      if (rd_q) begin
         rd_iq_d = rd_word[WIDTH-1:0];
      end else if (rd_i) begin
         rd_iq_d = rd_word[2*WIDTH-1:WIDTH];
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values, independent of block order.
   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         wr_count_q <= '0;
         full_q     <= 1'b0;
         rd_iq_q    <= '0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         wr_count_q <= wr_count_d;
         full_q     <= full_d;
         rd_iq_q    <= rd_iq_d;
      end
   end

   // NOTE: the sample RAM has no reset; clearing it would prevent block-RAM mapping and valid data is tracked by wr_count.
   always_ff @(posedge adc_clk) begin
      if (wr_accept) mem[wr_addr_q] <= {wr_i, wr_q};
   end

   assign full     = full_q;
   assign wr_count = wr_count_q;
   assign rd_iq    = rd_iq_q;

`ifdef WF_CAPTURE_OVERRUN_EN
   logic [15:0] ovr_count_q, ovr_count_d;

   always_comb begin
      ovr_count_d = ovr_count_q;
      if (wr_rst) begin
         ovr_count_d = '0;
      end else if (wr && !wr_continuous && full_q && ovr_count_q != 16'hFFFF) begin
         ovr_count_d = ovr_count_q + 16'd1;
      end
   end

   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n) ovr_count_q <= '0;
      else          ovr_count_q <= ovr_count_d;
   end

   assign ovr_count = ovr_count_q;
`endif

endmodule

// File: tb/tb_wf_iq_capture.sv
// Self-checking bench for wf_iq_capture (DEPTH=16): expected read data is queued when a
// read strobe is driven and compared against rd_iq after the capturing edge.
`timescale 1ns/1ps

module tb_wf_iq_capture;

   localparam int WIDTH     = 16;
   localparam int ADDR_BITS = 4;

   logic                 adc_clk = 1'b0;
   logic                 reset_n;
   logic                 wr_rst, wr_continuous, wr;
   logic [WIDTH-1:0]     wr_i, wr_q;
   logic                 full;
   logic [ADDR_BITS:0]   wr_count;
   logic                 rd_rst, rd_sync, rd_i, rd_q;
   logic [WIDTH-1:0]     rd_iq;
`ifdef WF_CAPTURE_OVERRUN_EN
   logic [15:0]          ovr_count;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] sb[$];

   always #5 adc_clk = ~adc_clk;

   wf_iq_capture #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
      .adc_clk       (adc_clk),
      .reset_n       (reset_n),
      .wr_rst        (wr_rst),
      .wr_continuous (wr_continuous),
      .wr            (wr),
      .wr_i          (wr_i),
      .wr_q          (wr_q),
      .full          (full),
      .wr_count      (wr_count),
      .rd_rst        (rd_rst),
      .rd_sync       (rd_sync),
      .rd_i          (rd_i),
      .rd_q          (rd_q),
      .rd_iq         (rd_iq)
`ifdef WF_CAPTURE_OVERRUN_EN
     ,.ovr_count     (ovr_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge adc_clk);
      #1;
   endtask

   task automatic pop_check(input string tag);
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: no expected value queued, got 0x%0h", tag, rd_iq);
      end else begin
         check(tag, 32'(rd_iq), 32'(sb.pop_front()));
      end
   endtask

   task automatic write(input logic [15:0] i, input logic [15:0] q);
      wr = 1'b1; wr_i = i; wr_q = q;
      cycle();
      wr = 1'b0;
   endtask

   task automatic read_pair(input string tag, input logic [15:0] ei, input logic [15:0] eq);
      rd_i = 1'b1; sb.push_back(ei);
      cycle();
      rd_i = 1'b0;
      pop_check({tag, "_i"});
      rd_q = 1'b1; sb.push_back(eq);
      cycle();
      rd_q = 1'b0;
      pop_check({tag, "_q"});
   endtask

   task automatic pulse_wr_rst();
      wr_rst = 1'b1; cycle(); wr_rst = 1'b0;
   endtask

   task automatic pulse_rd_rst();
      rd_rst = 1'b1; cycle(); rd_rst = 1'b0;
   endtask

   task automatic pulse_rd_sync();
      rd_sync = 1'b1; cycle(); rd_sync = 1'b0;
   endtask

   task automatic check_ovr(input string tag, input logic [15:0] exp);
`ifdef WF_CAPTURE_OVERRUN_EN
      check(tag, 32'(ovr_count), 32'(exp));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; wr_rst = 1'b0; wr_continuous = 1'b0; wr = 1'b0;
      wr_i = '0; wr_q = '0; rd_rst = 1'b0; rd_sync = 1'b0; rd_i = 1'b0; rd_q = 1'b0;
      repeat (2) cycle();
      check("rst_full", 32'(full), 32'd0);
      check("rst_count", 32'(wr_count), 32'd0);
      check("rst_rd_iq", 32'(rd_iq), 32'd0);
      check_ovr("rst_ovr", 16'd0);
      reset_n = 1'b1;
      cycle();

      // One-shot fill: 20 writes, only the first 16 land.
      for (int n = 0; n < 20; n++) begin
         write(16'(n), 16'(16'h100 + n));
         if (n == 14) check("os_full_early", 32'(full), 32'd0);
         if (n == 15) begin
            check("os_full_16", 32'(full), 32'd1);
            check("os_count_16", 32'(wr_count), 32'd16);
         end
      end
      check("os_full_end", 32'(full), 32'd1);
      check("os_count_end", 32'(wr_count), 32'd16);
      check_ovr("os_ovr", 16'd4);
      pulse_rd_rst();
      for (int n = 0; n < 16; n++) read_pair($sformatf("os%0d", n), 16'(n), 16'(16'h100 + n));

      // Latency / hold: rd_addr wrapped back to 0.
      rd_q = 1'b1; sb.push_back(16'h100);
      cycle();
      rd_q = 1'b0;
      pop_check("lat_q0");
      rd_i = 1'b1; sb.push_back(16'd1);
      cycle();
      rd_i = 1'b0;
      pop_check("lat_i1");
      for (int k = 0; k < 3; k++) begin
         cycle();
         check($sformatf("hold%0d", k), 32'(rd_iq), 32'd1);
      end
      rd_i = 1'b1; rd_q = 1'b1; sb.push_back(16'h101);
      cycle();
      rd_i = 1'b0; rd_q = 1'b0;
      pop_check("both_is_q");
      rd_i = 1'b1; sb.push_back(16'd2);
      cycle();
      rd_i = 1'b0;
      pop_check("after_both");

      // Continuous wrap: 20 writes, oldest sample sits at address 4.
      pulse_wr_rst();
      check("wrst_full", 32'(full), 32'd0);
      check("wrst_count", 32'(wr_count), 32'd0);
      check_ovr("wrst_ovr", 16'd0);
      wr_continuous = 1'b1;
      for (int n = 0; n < 20; n++) write(16'(n), 16'(16'h100 + n));
      check("ring_full", 32'(full), 32'd1);
      check("ring_count", 32'(wr_count), 32'd16);
      pulse_rd_sync();
      for (int k = 0; k < 16; k++) read_pair($sformatf("ring%0d", k), 16'(4 + k), 16'(16'h104 + k));

      // Continuous -> one-shot while full drops the write, so the oldest slot stays at 4.
      wr_continuous = 1'b0;
      write(16'h00AA, 16'h01AA);
      check_ovr("switch_ovr", 16'd1);
      check("switch_count", 32'(wr_count), 32'd16);
      wr_continuous = 1'b1;
      pulse_rd_sync();
      read_pair("switch", 16'd4, 16'h104);

      // wr_rst coincident with wr.
      wr_continuous = 1'b0;
      wr_rst = 1'b1; wr = 1'b1; wr_i = 16'h0055; wr_q = 16'h0155;
      cycle();
      wr_rst = 1'b0; wr = 1'b0;
      check("wrst_wr_count", 32'(wr_count), 32'd0);
      check("wrst_wr_full", 32'(full), 32'd0);
      check_ovr("wrst_wr_ovr", 16'd0);
      write(16'h0077, 16'h0177);
      check("single_count", 32'(wr_count), 32'd1);
      pulse_rd_rst();
      read_pair("single", 16'h0077, 16'h0177);

      // Collision at address 1: old I first, new I on re-read.
      wr = 1'b1; wr_i = 16'h0099; wr_q = 16'h0199; rd_i = 1'b1; sb.push_back(16'd17);
      cycle();
      wr = 1'b0; rd_i = 1'b0;
      pop_check("coll_old");
      read_pair("coll_new", 16'h0099, 16'h0199);

      // Async reset mid-capture.
      pulse_wr_rst();
      for (int n = 0; n < 7; n++) write(16'(16'h20 + n), 16'(16'h120 + n));
      check("pre_arst_count", 32'(wr_count), 32'd7);
      #2;
      reset_n = 1'b0;
      #0.5;
      check("arst_full", 32'(full), 32'd0);
      check("arst_count", 32'(wr_count), 32'd0);
      check("arst_rd_iq", 32'(rd_iq), 32'd0);
      check_ovr("arst_ovr", 16'd0);
      #0.5;
      reset_n = 1'b1;
      cycle();
      write(16'h0033, 16'h0133);
      check("post_arst_count", 32'(wr_count), 32'd1);
      pulse_rd_sync();
      read_pair("post_arst", 16'h0033, 16'h0133);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wf_iq_capture.md
Name: wf_iq_capture

Overview:
- Single-clock IQ capture buffer directly downstream of the waterfall CIC pair.
- Accepts decimated I/Q sample pairs on the CIC output strobe and stores them in on-chip RAM.
- Supports one-shot and continuous ring capture. Presents samples as an interleaved 16-bit I, Q read stream for the FFT/readout path in the adc_clk domain.
- Replaces the dual-clock sampler where the consumer runs on adc_clk.

Parameters:
- WIDTH, 16, bit width of each I and Q sample (matches WFO_BITS).
- ADDR_BITS, 13, log2 of buffer depth in IQ pairs; DEPTH = 2**ADDR_BITS.

Ports:
- adc_clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_rst  in  1  sync pulse: clear write pointer, full flag and read pointer.
- wr_continuous  in  1  1 = ring mode, 0 = one-shot; sampled every cycle.
- wr  in  1  write strobe (CIC out_strobe).
- wr_i  in  WIDTH  I sample.
- wr_q  in  WIDTH  Q sample.
- full  out  1  buffer holds DEPTH valid pairs.
- wr_count  out  ADDR_BITS+1  valid pairs stored, saturates at DEPTH.
- rd_rst  in  1  sync pulse: read pointer to 0.
- rd_sync  in  1  sync pulse: read pointer to oldest stored sample.
- rd_i  in  1  read-I strobe.
- rd_q  in  1  read-Q strobe; advances read pointer.
- rd_iq  out  WIDTH  registered read data.

Behaviour:
- Async reset (reset_n=0): wr_addr=0, rd_addr=0, full=0, wr_count=0, rd_iq=0. RAM contents undefined.
- Storage: DEPTH x 2*WIDTH RAM, {I,Q} per entry. Single write port, single synchronous read port, read-first on address collision.
- Write, one-shot mode:
  - wr && !full: store {wr_i,wr_q} at wr_addr, wr_addr++, wr_count++.
  - When wr_count reaches DEPTH: full=1 the cycle after the last write.
  - Further wr while full is ignored; data is unchanged.
- Write, continuous mode:
  - Every wr is stored; wr_addr wraps DEPTH-1 -> 0.
  - full sets on the first wrap and stays set until wr_rst or reset.
  - wr_count saturates at DEPTH.
- Mode switch: switching mode mid-capture takes effect on the next wr. Switching continuous -> one-shot with full=1 stops writes immediately.
- wr_rst:
  - Takes effect next edge: wr_addr=0, full=0, wr_count=0, rd_addr=0.
  - wr in the same cycle is dropped (reset wins).
- Read:
  - rd_i: rd_iq <= I of RAM[rd_addr], valid the cycle after the strobe (latency 1).
  - rd_q: rd_iq <= Q of RAM[rd_addr], valid the next cycle; rd_addr increments (wraps) that same edge.
  - Consumers issue rd_i then rd_q per pair, at most one strobe per cycle.
  - rd_i && rd_q together: treated as rd_q only.
  - With no strobe, rd_iq holds its value.
- rd_sync:
  - Continuous mode with full=1: rd_addr <= wr_addr, i.e. oldest sample; this includes a wr on the same cycle, using the post-write pointer.
  - Otherwise: rd_addr <= 0.
- Pointer-control priority: wr_rst > rd_rst > rd_sync > rd_q increment. A read strobe coincident with rd_rst/rd_sync still returns data from the pre-update rd_addr.
- Reads are never blocked. Reading past wr_count returns stale RAM contents, which is legal.

Optional Feature:
- Macro: WF_CAPTURE_OVERRUN_EN.
- When defined:
  - Adds output ovr_count [15:0].
  - Counts wr strobes dropped in one-shot mode while full=1, saturating at 16'hFFFF.
  - Cleared by wr_rst and reset_n.
- When undefined: the port and counter are absent, and dropped writes are silent.

Test Plan:
- Bench uses ADDR_BITS=4 (DEPTH=16), WIDTH=16.
- One-shot fill: 20 wr pulses with I=n, Q=0x100+n, n=0..19 -> full=1 after the 16th, wr_count=16. A read of 16 pairs returns I=0..15, Q=0x100..0x10F; with the macro, ovr_count=4.
- Continuous wrap: 20 writes as above, then rd_sync -> rd_addr=4. The first pair read is I=4, Q=0x104, the 13th is I=16, and the 16th is I=19.
- Read latency: rd_i at cycle t -> rd_iq valid at t+1. Strobe idle at t+1..t+3 -> rd_iq held.
- wr_rst coincident with wr: the sample is dropped; wr_count=0 and full=0 the next cycle. A following single write lands at address 0.
- Async reset mid-capture: reset_n low for 1 ns between edges after 7 writes -> all outputs 0 immediately. After release, writes restart at address 0.
- Collision: wr and rd_i on the same address and cycle -> rd_iq returns the old I, and a re-read returns the new I.
